biquad_mult_sched: RTL



---
 rtl/biquad_pkg.sv | 24 ++
 rtl/biquad_mult_sched_if.sv | 34 +++
 rtl/biquad_rr_arb.sv | 80 ++++++++
 rtl/biquad_mult_sched.sv | 132 +++++++++++++
 4 files changed

// File: rtl/biquad_pkg.sv
// rtl/biquad_pkg.sv - shared widths, tap indices and scheduler state encoding for the biquad multiplier scheduler
// Optional build macro: BIQUAD_MULT_SCHED_PRIO0_EN (consumed by biquad_rr_arb).
package biquad_pkg;

    localparam int A_W          = 9;
    localparam int B_W          = 13;
    localparam int P_W          = A_W + B_W;
    localparam int MULT_LAT     = 5;
    localparam int NREQ_DEFAULT = 5;

    // Requester index of each coefficient tap.
    localparam int TAP_B0 = 0;
    localparam int TAP_B1 = 1;
    localparam int TAP_B2 = 2;
    localparam int TAP_A1 = 3;
    localparam int TAP_A2 = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_e;

endpackage

// File: rtl/biquad_mult_sched_if.sv
// rtl/biquad_mult_sched_if.sv - requester, control and multiplier bus of the biquad multiplier scheduler
// Requester side: req, op_a, op_b (packed, requester i at [i*W +: W]), gnt, rsp_valid, rsp_p.
// Control: halt, idle.  Multiplier side: mult_a, mult_b, mult_en, mult_p.
// slave = scheduler view, master = requesters/multiplier view.
interface biquad_mult_sched_if
    import biquad_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT
) ();

    logic [NREQ-1:0]     req;
    logic [NREQ*A_W-1:0] op_a;
    logic [NREQ*B_W-1:0] op_b;
    logic [NREQ-1:0]     gnt;
    logic                halt;
    logic                idle;
    logic [NREQ-1:0]     rsp_valid;
    logic [P_W-1:0]      rsp_p;
    logic [A_W-1:0]      mult_a;
    logic [B_W-1:0]      mult_b;
    logic                mult_en;
    logic [P_W-1:0]      mult_p;

    modport slave (
        input  req, op_a, op_b, halt, mult_p,
        output gnt, idle, rsp_valid, rsp_p, mult_a, mult_b, mult_en
    );

    modport master (
        output req, op_a, op_b, halt, mult_p,
        input  gnt, idle, rsp_valid, rsp_p, mult_a, mult_b, mult_en
    );

endinterface

// File: rtl/biquad_rr_arb.sv
// rtl/biquad_rr_arb.sv - round-robin picker with pointer, one-hot grant and grant index
// Ports: clk, rst_n (async active-low), en (grant allowed), req[NREQ],
//        gnt[NREQ] one-hot, idx winner index, any (a grant was issued).
// Macro BIQUAD_MULT_SCHED_PRIO0_EN: requester 0 wins outright and leaves the pointer alone;
// the remaining requesters rotate among themselves.
module biquad_rr_arb #(
    parameter int NREQ  = 5,
    parameter int TAG_W = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic [TAG_W-1:0] idx,
    output logic             any
);

    logic [TAG_W-1:0] ptr_q, ptr_d;
    logic [NREQ-1:0]  rr_req;
    logic             rr_hit;
    logic [TAG_W-1:0] rr_idx;
    logic             hit;
    logic             move;
    logic [TAG_W-1:0] sel;
    int               cand;

    always_comb begin
        rr_req = req;
`ifdef BIQUAD_MULT_SCHED_PRIO0_EN
        rr_req[0] = 1'b0;
`endif
        rr_hit = 1'b0;
        rr_idx = '0;
        cand   = 0;
        // Search ptr+1, ptr+2, ... with wrap; the first requester found wins.
        for (int off = 1; off <= NREQ; off++) begin
            cand = int'(ptr_q) + off;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!rr_hit && rr_req[cand[TAG_W-1:0]]) begin
                rr_hit = 1'b1;
                rr_idx = cand[TAG_W-1:0];
            end
        end

        hit  = rr_hit;
        sel  = rr_idx;
        move = rr_hit;
`ifdef BIQUAD_MULT_SCHED_PRIO0_EN
        if (req[0]) begin
            hit  = 1'b1;
            sel  = '0;
            move = 1'b0;
        end
`endif

        gnt   = '0;
        ptr_d = ptr_q;
        if (en && hit) begin
            gnt[sel] = 1'b1;
            if (move) begin
                ptr_d = sel;
            end
        end
        any = en & hit;
        idx = any ? sel : '0;
    end

    // Pointer starts at NREQ-1 so requester 0 is first in line after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= TAG_W'(NREQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/biquad_mult_sched.sv
// rtl/biquad_mult_sched.sv - shares one pipelined 9x13 multiplier among the biquad tap requesters
// Ports: clk, rst_n (async active-low), bus (biquad_mult_sched_if.slave):
//   req/op_a/op_b in, gnt out (combinational), halt in, idle out,
//   rsp_valid/rsp_p out (combinational from last tag stage), mult_a/mult_b/mult_en out, mult_p in.
// Macro BIQUAD_MULT_SCHED_PRIO0_EN: requester 0 has absolute priority (see biquad_rr_arb).
module biquad_mult_sched
    import biquad_pkg::*;
#(
    parameter int NREQ  = NREQ_DEFAULT,
    parameter int TAG_W = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    biquad_mult_sched_if.slave  bus
);

    sched_state_e                 state_q, state_d;
    logic [MULT_LAT:0]            tag_v_q, tag_v_d;
    logic [MULT_LAT:0][TAG_W-1:0] tag_idx_q, tag_idx_d;
    logic [A_W-1:0]               mult_a_q, mult_a_d;
    logic [B_W-1:0]               mult_b_q, mult_b_d;

    logic                         grant_en;
    logic [NREQ-1:0]              arb_gnt;
    logic [TAG_W-1:0]             arb_idx;
    logic                         arb_any;
    logic                         mult_en;
    logic                         pipe_empty_next;
    logic [NREQ-1:0]              rsp_valid;
    logic [P_W-1:0]               rsp_p;

    assign grant_en = ~bus.halt & (state_q != ST_DRAIN);

    biquad_rr_arb #(
        .NREQ  (NREQ),
        .TAG_W (TAG_W)
    ) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (grant_en),
        .req   (bus.req),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    // Tag shadow pipe tracks the multiplier stage for stage; it advances only
    // when the multiplier is enabled, which is whenever any tag is in flight.
    // Stage 0 loads every cycle: when the pipe is empty nothing is lost.
    always_comb begin
        mult_en   = |tag_v_q;
        tag_v_d   = tag_v_q;
        tag_idx_d = tag_idx_q;
        if (mult_en) begin
            for (int k = MULT_LAT; k >= 1; k--) begin
                tag_v_d[k]   = tag_v_q[k-1];
                tag_idx_d[k] = tag_idx_q[k-1];
            end
        end
        tag_v_d[0]   = arb_any;
        tag_idx_d[0] = arb_any ? arb_idx : '0;

        mult_a_d = mult_a_q;
        mult_b_d = mult_b_q;
        if (arb_any) begin
            mult_a_d = bus.op_a[int'(arb_idx)*A_W +: A_W];
            mult_b_d = bus.op_b[int'(arb_idx)*B_W +: B_W];
        end
    end

    // Pipe is empty next cycle when nothing below the last stage is valid and
    // nothing is issued now; this lets idle rise the cycle after the last product.
    assign pipe_empty_next = ~|tag_v_q[MULT_LAT-1:0] & ~arb_any;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.halt) begin
                    state_d = pipe_empty_next ? ST_IDLE : ST_DRAIN;
                end else if (pipe_empty_next && ~|bus.req) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (pipe_empty_next) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            tag_v_q   <= '0;
            tag_idx_q <= '0;
            mult_a_q  <= '0;
            mult_b_q  <= '0;
        end else begin
            state_q   <= state_d;
            tag_v_q   <= tag_v_d;
            tag_idx_q <= tag_idx_d;
            mult_a_q  <= mult_a_d;
            mult_b_q  <= mult_b_d;
        end
    end

    always_comb begin
        rsp_valid = '0;
        rsp_p     = '0;
        if (tag_v_q[MULT_LAT]) begin
            rsp_valid[tag_idx_q[MULT_LAT]] = 1'b1;
            rsp_p                          = bus.mult_p;
        end
    end

    assign bus.gnt       = arb_gnt;
    assign bus.idle      = (state_q == ST_IDLE) & ~arb_any;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_p     = rsp_p;
    assign bus.mult_a    = mult_a_q;
    assign bus.mult_b    = mult_b_q;
    assign bus.mult_en   = mult_en;

endmodule
